// File: rtl/test_exit_monitor.sv
// test_exit_monitor
// Passive observer for test builds. It snoops NUM_PORTS write channels for two
// addresses:
//   - the exit address, which ends the test with a pass/fail result
//   - the console address, whose low data byte is queued in a small FIFO
// An optional cycle limit ends the test with a timeout. The block drives no
// memory-side signals.
//
// state      | meaning
// ST_RUNNING | counting cycles; watching for an exit write or the timeout
// ST_DONE    | result latched; terminal until reset
module test_exit_monitor #(
  parameter int                    NUM_PORTS      = 1,
  parameter int                    ADDR_WIDTH     = 64,
  parameter int                    DATA_WIDTH     = 64,
  parameter logic [ADDR_WIDTH-1:0] EXIT_ADDR      = 'h1000,
  parameter logic [DATA_WIDTH-1:0] WDATA_SUCCESS  = 1,
  parameter int                    CHECK_MODE     = 0,
  parameter logic [ADDR_WIDTH-1:0] CONSOLE_ADDR   = 'h1008,
  parameter int                    CONSOLE_DEPTH  = 8,
  parameter int unsigned           TIMEOUT_CYCLES = 0,
  parameter bit                    ENABLE         = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_PORTS-1:0]              i_valid,
  input  logic [NUM_PORTS-1:0]              i_ready,
  input  logic [NUM_PORTS-1:0]              i_wen,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   i_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   i_wdata,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] i_wmask,
  output logic                              o_done,
  output logic                              o_pass,
  output logic                              o_timeout,
  output logic [DATA_WIDTH-1:0]             o_fail_code,
  output logic                              o_putc_valid,
  output logic [7:0]                        o_putc_data,
  input  logic                              i_putc_ready,
  output logic                              o_putc_overflow,
  output logic [31:0]                       o_cycle
);

  localparam int          STRB_W       = DATA_WIDTH / 8;
  localparam int          AW           = $clog2(CONSOLE_DEPTH);
  localparam int          PTR_W        = AW + 1;
  localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  typedef enum logic {
    ST_RUNNING = 1'b0,
    ST_DONE    = 1'b1
  } state_t;

  state_t                  state;
  logic                    done_q;
  logic                    pass_q;
  logic                    timeout_q;
  logic [DATA_WIDTH-1:0]   fail_code_q;
  logic [31:0]             cycle_q;

  logic [NUM_PORTS-1:0]    fire;
  logic [NUM_PORTS-1:0]    exit_hit;
  logic [NUM_PORTS-1:0]    con_hit;
  logic [DATA_WIDTH-1:0]   masked [NUM_PORTS];

  logic                    exit_any;
  logic [DATA_WIDTH-1:0]   exit_data;
  logic                    exit_pass;
  logic [DATA_WIDTH-1:0]   exit_code;
  logic                    timeout_hit;

  logic [7:0]              fifo_mem [CONSOLE_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W-1:0]        fill;
  logic                    fifo_empty;
  logic                    pop;
  logic                    overflow_q;
  logic [NUM_PORTS-1:0]    push_en;
  logic [AW-1:0]           push_slot [NUM_PORTS];
  logic [7:0]              push_byte [NUM_PORTS];
  logic [PTR_W-1:0]        push_count;
  logic                    drop_any;
  logic [PTR_W-1:0]        slot_full;
  int                      n_push;
  int                      free_slots;

  // Per-port handshake qualification, byte masking and address classification
  always_comb begin
    fire     = '0;
    exit_hit = '0;
    con_hit  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      masked[p] = '0;
      for (int b = 0; b < STRB_W; b++) begin
        masked[p][8*b +: 8] = i_wmask[p*STRB_W + b] ? i_wdata[p*DATA_WIDTH + 8*b +: 8] : 8'h00;
      end
      fire[p]     = i_valid[p] & i_ready[p] & i_wen[p];
      exit_hit[p] = fire[p] && (i_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == EXIT_ADDR)
                    && (|i_wmask[p*STRB_W +: STRB_W]);
      con_hit[p]  = fire[p] && (i_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == CONSOLE_ADDR)
                    && i_wmask[p*STRB_W];
    end
  end

  // Lowest-index exit write wins; the others in the same cycle are ignored
  always_comb begin
    exit_any  = 1'b0;
    exit_data = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (exit_hit[p] && !exit_any) begin
        exit_any  = 1'b1;
        exit_data = masked[p];
      end
    end
  end

  // Result decode: exact compare, or tohost style (bit0 marks a valid code)
  always_comb begin
    exit_pass = 1'b0;
    exit_code = exit_data;
    if (CHECK_MODE == 0) begin
      exit_pass = (exit_data == WDATA_SUCCESS);
      exit_code = exit_pass ? '0 : exit_data;
    end else if (exit_data[0]) begin
      exit_code = exit_data >> 1;
      exit_pass = (exit_code == '0);
    end
  end

  assign timeout_hit = TIMEOUT_EN && (cycle_q == TIMEOUT_LAST);

  // Run/done sequencing with the latched result and the saturating cycle count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_RUNNING;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      fail_code_q <= '0;
      cycle_q     <= '0;
    end else begin
      case (state)
        ST_RUNNING: begin
          if (cycle_q != '1) cycle_q <= cycle_q + 32'd1;
          if (exit_any) begin
            state       <= ST_DONE;
            done_q      <= 1'b1;
            pass_q      <= exit_pass;
            fail_code_q <= exit_code;
          end else if (timeout_hit) begin
            state       <= ST_DONE;
            done_q      <= 1'b1;
            timeout_q   <= 1'b1;
            pass_q      <= 1'b0;
            fail_code_q <= '0;
          end
        end
        default: begin
          state <= ST_DONE;
        end
      endcase
    end
  end

  assign fill       = wr_ptr - rd_ptr;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign pop        = ENABLE && !fifo_empty && i_putc_ready;

  // Console push allocation: ascending port order into the space left after any pop
  always_comb begin
    push_en    = '0;
    drop_any   = 1'b0;
    n_push     = 0;
    slot_full  = '0;
    free_slots = CONSOLE_DEPTH - int'(fill) + (pop ? 1 : 0);
    for (int p = 0; p < NUM_PORTS; p++) begin
      push_slot[p] = '0;
      push_byte[p] = i_wdata[p*DATA_WIDTH +: 8];
      if (con_hit[p]) begin
        if (n_push < free_slots) begin
          slot_full    = wr_ptr + PTR_W'(n_push);
          push_en[p]   = 1'b1;
          push_slot[p] = slot_full[AW-1:0];
          n_push       = n_push + 1;
        end else begin
          drop_any = 1'b1;
        end
      end
    end
    push_count = PTR_W'(n_push);
  end

  // FIFO pointers and the sticky overflow flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      wr_ptr <= wr_ptr + push_count;
      if (drop_any) overflow_q <= 1'b1;
    end
  end

  // FIFO storage; contents are only visible while the FIFO is non-empty
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (push_en[p]) fifo_mem[push_slot[p]] <= push_byte[p];
    end
  end

  assign o_done          = ENABLE && done_q;
  assign o_pass          = ENABLE && pass_q;
  assign o_timeout       = ENABLE && timeout_q;
  assign o_fail_code     = ENABLE ? fail_code_q : '0;
  assign o_cycle         = ENABLE ? cycle_q : 32'd0;
  assign o_putc_valid    = ENABLE && !fifo_empty;
  assign o_putc_data     = (ENABLE && !fifo_empty) ? fifo_mem[rd_ptr[AW-1:0]] : 8'h00;
  assign o_putc_overflow = ENABLE && overflow_q;

endmodule

// File: doc/test_exit_monitor.md
Name: test_exit_monitor

Overview:
- Simulation/FPGA-test block that snoops NUM_PORTS memory write channels for writes to the test exit address and the console address.
- Decodes pass/fail in a selectable encoding, enforces an optional cycle-count timeout, and buffers console bytes in a small FIFO.
- Sits beside the memory interconnect in test builds; it drives no memory signals and is a pure observer.

Parameters:
- NUM_PORTS, 1, number of monitored write channels (1..4)
- ADDR_WIDTH, 64, address width
- DATA_WIDTH, 64, write data width (multiple of 8)
- EXIT_ADDR, 'h1000, exit address (exact match)
- WDATA_SUCCESS, 1, pass value when CHECK_MODE=0
- CHECK_MODE, 0, 0: exact compare against WDATA_SUCCESS; 1: tohost encoding (bit0=1 required, code=data>>1, code 0 = pass)
- CONSOLE_ADDR, 'h1008, console putc address
- CONSOLE_DEPTH, 8, console FIFO depth (power of two, ≥2)
- TIMEOUT_CYCLES, 0, timeout limit; 0 disables
- ENABLE, 1, 0 ties every output to its reset value

Ports:
- clk input 1 clock
- rst input 1 asynchronous active-low reset
- i_valid input NUM_PORTS per-port request valid
- i_ready input NUM_PORTS per-port request ready
- i_wen input NUM_PORTS per-port write enable
- i_addr input NUM_PORTS*ADDR_WIDTH packed addresses, port 0 in the LSBs
- i_wdata input NUM_PORTS*DATA_WIDTH packed write data
- i_wmask input NUM_PORTS*(DATA_WIDTH/8) packed byte enables
- o_done output 1 sticky, test finished
- o_pass output 1 valid when o_done
- o_timeout output 1 sticky, done was caused by timeout
- o_fail_code output DATA_WIDTH failure code (0 on pass)
- o_putc_valid output 1 console byte available
- o_putc_data output 8 console byte
- i_putc_ready input 1 consumer accepts byte
- o_putc_overflow output 1 sticky, a console byte was dropped
- o_cycle output 32 cycles spent in RUNNING, saturating

Behaviour:
- Handshake: a port fires when i_valid & i_ready & i_wen. Masked data = wdata with disabled bytes forced to 0.
- Reset (async assert, sync deassert): state RUNNING; every output 0; FIFO empty; cycle counter 0.
- RUNNING state:
  - o_cycle increments each cycle, saturating at 2^32-1.
  - Exit fire: the lowest-index port with addr==EXIT_ADDR and a nonzero mask wins; other simultaneous exit fires are ignored.
  - Next cycle: state DONE, o_done=1.
  - CHECK_MODE=0: o_pass=(masked data==WDATA_SUCCESS); o_fail_code = 0 on pass, else the masked data.
  - CHECK_MODE=1: bit0=0 is a fail with code = masked data; otherwise code=data>>1, o_pass=(code==0), o_fail_code=code.
  - Timeout: if TIMEOUT_CYCLES≠0, no exit fire this cycle, and o_cycle==TIMEOUT_CYCLES-1, then next cycle DONE with o_timeout=1, o_pass=0, o_fail_code=0.
  - An exit fire in the same cycle as the timeout threshold wins over the timeout.
- DONE state:
  - Terminal until reset. o_done, o_pass, o_timeout and o_fail_code are frozen.
  - Further exit writes are ignored; o_cycle is frozen.
- Console (active in both states):
  - Each fire with addr==CONSOLE_ADDR and mask bit0 set enqueues wdata[7:0].
  - Multiple console fires in one cycle enqueue in ascending port order, up to the free space that cycle; surplus bytes are dropped and set o_putc_overflow.
  - FIFO output: o_putc_valid = not empty; o_putc_data = head byte (first-word-fallthrough). Pop on o_putc_valid & i_putc_ready.
  - Simultaneous push and pop when full: the pop frees a slot the same cycle, so one push succeeds with no overflow.
  - Pointers are log2(CONSOLE_DEPTH)+1 bits and wrap naturally.
- A port matching neither address is ignored. Writes with i_wen=0 are never counted.
- Reset mid-run clears DONE, the FIFO and all sticky flags immediately, with no clock needed.

Test Plan:
- CHECK_MODE=0, port0 writes 1 to 'h1000 mask 'hFF → o_done=1, o_pass=1, o_fail_code=0 one cycle after the handshake.
- CHECK_MODE=1, write 'h7 → o_pass=0, o_fail_code=3. Then write 'h1 → no change (DONE is frozen).
- NUM_PORTS=2, same-cycle exit writes: port0 'h1, port1 'h5 (mode 1) → pass (port0 wins). Swap the values → fail, code 2.
- TIMEOUT_CYCLES=100, no exit write → o_done=1 and o_timeout=1 with o_cycle=100. Exit write landing on the threshold cycle → o_pass from the exit, o_timeout=0.
- CONSOLE_DEPTH=4, i_putc_ready=0, push 'H','e','l','l','o' → 'o' dropped, overflow=1. Then ready=1 → drains H,e,l,l in order, one per cycle.
- Assert rst while o_done=1 and the FIFO is non-empty → all outputs 0 asynchronously; next exit write is decoded normally.
